// File: rtl/shift_reg_universal.sv
// Universal shift register (hold / shift right / shift left / parallel load) with a per-word shift counter.
// Latency: q, serial taps and counters update 1 cycle after an enabled edge; outputs are pure register taps.
// No backpressure: en=0 stalls all state. Optional rotate feedback is built when SHREG_ROTATE_EN is defined.
module shift_reg_universal #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         sin_msb,
  input  logic                         sin_lsb,
`ifdef SHREG_ROTATE_EN
  input  logic                         rotate,
`endif
  input  logic [WIDTH-1:0]             pdata_in,
  output logic [WIDTH-1:0]             pdata_out,
  output logic                         sout_lsb,
  output logic                         sout_msb,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         word_done
);

  localparam int                CNT_W    = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q;
  logic             msb_in;
  logic             lsb_in;
  mode_e            mode_q;

  assign mode_q = mode_e'(mode);

`ifdef SHREG_ROTATE_EN
  // Rotation feeds the bit falling off one end back into the other.
  assign msb_in = rotate ? q[0]       : sin_msb;
  assign lsb_in = rotate ? q[WIDTH-1] : sin_lsb;
`else
  assign msb_in = sin_msb;
  assign lsb_in = sin_lsb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= RST_VAL;
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (en) begin
        unique case (mode_q)
          MODE_SHR: q <= {msb_in, q[WIDTH-1:1]};
          MODE_SHL: q <= {q[WIDTH-2:0], lsb_in};
          MODE_LOAD: begin
            q         <= pdata_in;
            shift_cnt <= '0;
          end
          default: ;
        endcase
        // Both shift directions count toward the same word.
        if (mode_q == MODE_SHR || mode_q == MODE_SHL) begin
          if (shift_cnt == CNT_LAST) begin
            shift_cnt <= '0;
            word_done <= 1'b1;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign pdata_out = q;
  assign sout_lsb  = q[0];
  assign sout_msb  = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal (WIDTH=8, RST_VAL=0); follows SHREG_ROTATE_EN if defined.
module tb_shift_reg_universal;

  localparam int W    = 8;
  localparam int CW   = $clog2(W+1);
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic          sin_msb;
  logic          sin_lsb;
  logic [W-1:0]  pdata_in;
`ifdef SHREG_ROTATE_EN
  logic          rotate;
`endif
  logic [W-1:0]  pdata_out;
  logic          sout_lsb;
  logic          sout_msb;
  logic [CW-1:0] shift_cnt;
  logic          word_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: register value as an integer, shift count, done flag.
  int mq;
  int mcnt;
  bit mdone;

  shift_reg_universal #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sin_msb   (sin_msb),
    .sin_lsb   (sin_lsb),
`ifdef SHREG_ROTATE_EN
    .rotate    (rotate),
`endif
    .pdata_in  (pdata_in),
    .pdata_out (pdata_out),
    .sout_lsb  (sout_lsb),
    .sout_msb  (sout_msb),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic bump();
    mcnt++;
    if (mcnt == W) begin
      mcnt  = 0;
      mdone = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, advance the model, sample at edge+1.
  task automatic cycle(input bit e, input logic [1:0] m, input bit sm, input bit sl, input logic [W-1:0] pd);
    bit mi;
    bit li;
    en = e; mode = m; sin_msb = sm; sin_lsb = sl; pdata_in = pd;
    mi = sm;
    li = sl;
`ifdef SHREG_ROTATE_EN
    if (rotate) begin
      mi = mq[0];
      li = mq[W-1];
    end
`endif
    @(posedge clk);
    #1;
    mdone = 1'b0;
    if (e) begin
      case (m)
        2'b01: begin mq = (mq >> 1) | (int'(mi) << (W-1)); bump(); end
        2'b10: begin mq = ((mq << 1) | int'(li)) & MASK;   bump(); end
        2'b11: begin mq = int'(pd); mcnt = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mq = 0; mcnt = 0; mdone = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sin_msb = 1'b0; sin_lsb = 1'b0; pdata_in = '0;
`ifdef SHREG_ROTATE_EN
    rotate = 1'b0;
`endif
    mq = 0; mcnt = 0; mdone = 1'b0;
    #12;
    checks++; if (pdata_out !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", pdata_out); end
    checks++; if (shift_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
    checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", word_done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    cycle(1, 2'b11, 0, 0, 8'hA5);
    repeat (3) cycle(1, 2'b01, 0, 0, 8'h00);
    checks++; if (shift_cnt !== CW'(3)) begin failures++; $display("FAIL areset_pre_cnt got=%0d exp=3", shift_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pdata_out !== 8'h00) begin failures++; $display("FAIL areset_q got=%h exp=00", pdata_out); end
    checks++; if (shift_cnt !== '0) begin failures++; $display("FAIL areset_cnt got=%0d exp=0", shift_cnt); end
    mq = 0; mcnt = 0; mdone = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_shift_right_word();
    logic [7:0] seq;
    seq = 8'b1010_0101;  // expected sout_lsb order, first value in bit 0
    cycle(1, 2'b11, 0, 0, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      checks++; if (sout_lsb !== seq[i]) begin failures++; $display("FAIL shr_sout[%0d] got=%b exp=%b", i, sout_lsb, seq[i]); end
      cycle(1, 2'b01, 0, 0, 8'h00);
      checks++; if (word_done !== (i == 7)) begin failures++; $display("FAIL shr_done[%0d] got=%b exp=%b", i, word_done, (i == 7)); end
    end
    checks++; if (pdata_out !== 8'h00) begin failures++; $display("FAIL shr_q got=%h exp=00", pdata_out); end
    checks++; if (shift_cnt !== '0) begin failures++; $display("FAIL shr_cnt got=%0d exp=0", shift_cnt); end
    cycle(1, 2'b00, 0, 0, 8'h00);
    checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL shr_done_pulse got=%b exp=0", word_done); end
  endtask

  task automatic test_shift_left();
    cycle(1, 2'b11, 0, 0, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2'b10, 0, 1, 8'h00);
      checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL shl_done[%0d] got=%b exp=0", i, word_done); end
    end
    checks++; if (pdata_out !== 8'h2F) begin failures++; $display("FAIL shl_q got=%h exp=2f", pdata_out); end
    checks++; if (shift_cnt !== CW'(3)) begin failures++; $display("FAIL shl_cnt got=%0d exp=3", shift_cnt); end
  endtask

  task automatic test_enable_hold();
    cycle(1, 2'b11, 0, 0, 8'h3C);
    repeat (2) cycle(1, 2'b01, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 2'b01, 1, 1, 8'hFF);
      checks++; if (pdata_out !== 8'h0F) begin failures++; $display("FAIL hold_q[%0d] got=%h exp=0f", i, pdata_out); end
      checks++; if (shift_cnt !== CW'(2)) begin failures++; $display("FAIL hold_cnt[%0d] got=%0d exp=2", i, shift_cnt); end
      checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL hold_done[%0d] got=%b exp=0", i, word_done); end
    end
  endtask

  task automatic test_siso();
    bit in_q[$];
    logic [3:0] pat;
    pat = 4'b1101;  // 1,0,1,1 driven in that order (bit 0 first)
    apply_reset();
    for (int n = 1; n <= 12; n++) begin
      bit b;
      b = (n <= 4) ? pat[n-1] : 1'b0;
      in_q.push_back(b);
      cycle(1, 2'b01, b, 0, 8'h00);
      if (n == 4) begin
        checks++; if (pdata_out !== W'(mq)) begin failures++; $display("FAIL sipo_q got=%h exp=%h", pdata_out, W'(mq)); end
      end
      // The bit entered on shift n-7 reaches q[0] after shift n.
      if (n >= 8) begin
        checks++; if (sout_lsb !== in_q[n-8]) begin failures++; $display("FAIL siso_out[%0d] got=%b exp=%b", n, sout_lsb, in_q[n-8]); end
      end
    end
  endtask

  task automatic test_rotate();
    cycle(1, 2'b11, 0, 0, 8'h81);
`ifdef SHREG_ROTATE_EN
    rotate = 1'b1;
    cycle(1, 2'b01, 0, 0, 8'h00);
    rotate = 1'b0;
    checks++; if (pdata_out !== 8'hC0) begin failures++; $display("FAIL rot_q got=%h exp=c0", pdata_out); end
`else
    cycle(1, 2'b01, 0, 0, 8'h00);
    checks++; if (pdata_out !== 8'h40) begin failures++; $display("FAIL rot_q got=%h exp=40", pdata_out); end
`endif
  endtask

  task automatic test_back_to_back();
    cycle(1, 2'b11, 0, 0, 8'h00);
    for (int i = 0; i < 24; i++) begin
      cycle(1, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 1'($urandom), 1'($urandom), 8'h00);
      checks++; if (word_done !== ((i % 8) == 7)) begin failures++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, word_done, ((i % 8) == 7)); end
      checks++; if (shift_cnt !== CW'((i + 1) % 8)) begin failures++; $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", i, shift_cnt, (i + 1) % 8); end
    end
  endtask

  task automatic test_load_at_wrap();
    cycle(1, 2'b11, 0, 0, 8'h00);
    repeat (7) cycle(1, 2'b10, 1, 1, 8'h00);
    cycle(1, 2'b11, 0, 0, 8'h5A);
    checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL wrapload_done got=%b exp=0", word_done); end
    checks++; if (shift_cnt !== '0) begin failures++; $display("FAIL wrapload_cnt got=%0d exp=0", shift_cnt); end
    checks++; if (pdata_out !== 8'h5A) begin failures++; $display("FAIL wrapload_q got=%h exp=5a", pdata_out); end
    cycle(1, 2'b01, 0, 0, 8'h00);
    checks++; if (shift_cnt !== CW'(1)) begin failures++; $display("FAIL wrapload_next got=%0d exp=1", shift_cnt); end
  endtask

  task automatic test_random();
    logic [W+CW+2:0] got;
    logic [W+CW+2:0] exp;
    for (int i = 0; i < 400; i++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
`ifdef SHREG_ROTATE_EN
      rotate = 1'($urandom);
`endif
      cycle($urandom_range(0, 7) != 0, m, 1'($urandom), 1'($urandom), 8'($urandom));
      got = {pdata_out, sout_lsb, sout_msb, shift_cnt, word_done};
      exp = {W'(mq), mq[0], mq[W-1], CW'(mcnt), mdone};
      checks++; if (got !== exp) begin failures++; $display("FAIL rand[%0d] got=%h exp=%h (q,lsb,msb,cnt,done)", i, got, exp); end
    end
`ifdef SHREG_ROTATE_EN
    rotate = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_shift_right_word();
    test_shift_left();
    test_enable_hold();
    test_siso();
    test_rotate();
    test_back_to_back();
    test_load_at_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
